// File: rtl/signed_minmax_tracker_if.sv
// Sample-in / window-result-out handshake bundle for signed_minmax_tracker.
// Index signals exist only when MINMAX_IDX_EN is defined.
interface signed_minmax_tracker_if #(
    parameter int IDXW = 4
);
    logic              in_valid;
    logic signed [3:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] out_max;
    logic signed [3:0] out_min;
    logic              out_alleq;
`ifdef MINMAX_IDX_EN
    logic [IDXW-1:0]   out_max_idx;
    logic [IDXW-1:0]   out_min_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_alleq,
        input  out_max_idx, out_min_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min, out_alleq,
        output out_max_idx, out_min_idx
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_alleq
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min, out_alleq
    );
`endif
endinterface

// File: rtl/signed_minmax_tracker.sv
// Running signed max/min over a window of WIN 4-bit samples, result held until consumed.
// Optional first-occurrence index outputs are enabled by defining MINMAX_IDX_EN.
module signed_minmax_tracker #(
    parameter int WIN  = 8,
    parameter int IDXW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    signed_minmax_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_POS = IDXW'(WIN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_count;
    logic signed [3:0] r_max;
    logic signed [3:0] r_min;
    logic              r_alleq;
`ifdef MINMAX_IDX_EN
    logic [IDXW-1:0]   r_max_idx;
    logic [IDXW-1:0]   r_min_idx;
`endif

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_gt_max;
    logic              w_lt_min;
    logic              w_differs;

    // Sign bit decides first; with equal signs the raw patterns order correctly as unsigned.
    function automatic logic signed_gt(input logic signed [3:0] a, input logic signed [3:0] b);
        if (a[3] != b[3])
            return ~a[3];
        return unsigned'(a) > unsigned'(b);
    endfunction

    assign w_accept  = bus.in_valid & w_in_ready & ~clear;
    assign w_last    = (r_count == LAST_POS);
    assign w_gt_max  = signed_gt(bus.in_data, r_max);
    assign w_lt_min  = signed_gt(r_min, bus.in_data);
    assign w_differs = (bus.in_data != r_max) || (bus.in_data != r_min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)           w_state_nxt = ST_ACC;
                ST_ACC:  if (w_accept && w_last) w_state_nxt = ST_HOLD;
                ST_HOLD: if (bus.out_ready)      w_state_nxt = ST_IDLE;
                default:                         w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Handshake flags decode the state register only, never in_valid.
    always_comb begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE)
                r_count <= IDXW'(1);
            else
                r_count <= r_count + IDXW'(1);
        end else if (r_state == ST_HOLD && bus.out_ready) begin
            r_count <= '0;
        end
    end

    // Statistics move only on accepted samples; ties never replace, so the first occurrence wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max   <= '0;
            r_min   <= '0;
            r_alleq <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_max   <= bus.in_data;
                r_min   <= bus.in_data;
                r_alleq <= 1'b1;
            end else begin
                if (w_gt_max)
                    r_max <= bus.in_data;
                if (w_lt_min)
                    r_min <= bus.in_data;
                if (w_differs)
                    r_alleq <= 1'b0;
            end
        end
    end

`ifdef MINMAX_IDX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_max_idx <= '0;
                r_min_idx <= '0;
            end else begin
                if (w_gt_max)
                    r_max_idx <= r_count;
                if (w_lt_min)
                    r_min_idx <= r_count;
            end
        end
    end

    assign bus.out_max_idx = r_max_idx;
    assign bus.out_min_idx = r_min_idx;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_max   = r_max;
    assign bus.out_min   = r_min;
    assign bus.out_alleq = r_alleq;

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench for signed_minmax_tracker with WIN=4: directed windows, backpressure, gaps, clear, async reset.
module tb_signed_minmax_tracker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    signed_minmax_tracker_if #(.IDXW(4)) bus ();

    signed_minmax_tracker #(.WIN(4), .IDXW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] mx;
        logic [3:0] mn;
        logic       eq;
        logic [3:0] mxi;
        logic [3:0] mni;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] mx, input logic [3:0] mn, input logic eq,
                        input logic [3:0] mxi, input logic [3:0] mni);
        exp_t e;
        e.mx = mx; e.mn = mn; e.eq = eq; e.mxi = mxi; e.mni = mni;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {3'b0, bus.in_ready},  4'd1);
        chk({tag, "_out_valid"}, {3'b0, bus.out_valid}, 4'd0);
        chk({tag, "_max"},       bus.out_max,           4'h0);
        chk({tag, "_min"},       bus.out_min,           4'h0);
        chk({tag, "_alleq"},     {3'b0, bus.out_alleq}, 4'd0);
`ifdef MINMAX_IDX_EN
        chk({tag, "_max_idx"},   bus.out_max_idx,       4'd0);
        chk({tag, "_min_idx"},   bus.out_min_idx,       4'd0);
`endif
    endtask

    // Monitor: every consumed result is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: result max=%h min=%h with no expected entry", bus.out_max, bus.out_min);
            end else begin
                e = sb.pop_front();
                chk("res_max",   bus.out_max,           e.mx);
                chk("res_min",   bus.out_min,           e.mn);
                chk("res_alleq", {3'b0, bus.out_alleq}, {3'b0, e.eq});
`ifdef MINMAX_IDX_EN
                chk("res_max_idx", bus.out_max_idx, e.mxi);
                chk("res_min_idx", bus.out_min_idx, e.mni);
`endif
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b1;

        #12;
        chk_reset_vals("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 3, -8, 7, -1 back to back
        push(4'h7, 4'h8, 1'b0, 4'd2, 4'd1);
        send(4'h3); send(4'h8); send(4'h7); send(4'hF);
        @(negedge clk);
        chk("w1_valid_hi",   {3'b0, bus.out_valid}, 4'd1);
        chk("w1_ready_lo",   {3'b0, bus.in_ready},  4'd0);
        @(negedge clk);
        chk("w1_valid_drop", {3'b0, bus.out_valid}, 4'd0);
        chk("w1_ready_back", {3'b0, bus.in_ready},  4'd1);
        @(posedge clk); #1;

        // all equal -3
        push(4'hD, 4'hD, 1'b1, 4'd0, 4'd0);
        send(4'hD); send(4'hD); send(4'hD); send(4'hD);
        idle(2);

        // sign boundary 0, -1, 7, -8
        push(4'h7, 4'h8, 1'b0, 4'd2, 4'd3);
        send(4'h0); send(4'hF); send(4'h7); send(4'h8);
        idle(2);

        // backpressure: 2, 5, 5, -2 with consumer stalled
        push(4'h5, 4'hE, 1'b0, 4'd1, 4'd3);
        send(4'h2); send(4'h5);
        bus.out_ready = 1'b0;
        send(4'h5); send(4'hE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {3'b0, bus.out_valid}, 4'd1);
            chk("bp_ready", {3'b0, bus.in_ready},  4'd0);
            chk("bp_max",   bus.out_max,           4'h5);
            chk("bp_min",   bus.out_min,           4'hE);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after", {3'b0, bus.in_ready},  4'd1);
        chk("bp_valid_after", {3'b0, bus.out_valid}, 4'd0);
        @(posedge clk); #1;

        // gaps: same samples as the first window
        push(4'h7, 4'h8, 1'b0, 4'd2, 4'd1);
        send(4'h3); idle(2);
        send(4'h8); idle(1);
        send(4'h7); idle(3);
        send(4'hF);
        idle(2);

        // clear after 2 samples with a same-cycle sample that must be ignored
        send(4'hB); send(4'h6);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h8;
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_valid", {3'b0, bus.out_valid}, 4'd0);
        chk("clr_ready", {3'b0, bus.in_ready},  4'd1);
        @(posedge clk); #1;
        push(4'h2, 4'h1, 1'b0, 4'd2, 4'd0);
        send(4'h1); send(4'h1); send(4'h2); send(4'h1);
        idle(2);

        // asynchronous reset mid-window
        send(4'h4); send(4'h4); send(4'h4);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push(4'h7, 4'h6, 1'b0, 4'd0, 4'd2);
        send(4'h7); send(4'h7); send(4'h6); send(4'h7);
        idle(3);

        chk("sb_drain", {3'b0, (sb.size() == 0)}, 4'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
